// File: rtl/periph_mmio_pkg.sv
// Shared constants for the MMIO peripheral block: window base, register offsets,
// TCON bit positions and the digit-scan state type.
package periph_mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Byte offsets inside the 256-byte window
  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_DIGI    = 8'h10;
  localparam logic [7:0] OFF_SYSTICK = 8'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Active-low one-hot anode pattern for the digit being scanned
  function automatic logic [3:0] an_onehot_n(input digit_e d);
    logic [3:0] an;
    unique case (d)
      DIG0:    an = 4'b1110;
      DIG1:    an = 4'b1101;
      DIG2:    an = 4'b1011;
      default: an = 4'b0111;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/periph_mmio_if.sv
// CPU-side load/store port of the MEM stage as seen by the peripheral window.
interface periph_mmio_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        hit;

  modport master (
    output Address, Write_data, MemRead, MemWrite,
    input  Read_data, hit
  );

  modport slave (
    input  Address, Write_data, MemRead, MemWrite,
    output Read_data, hit
  );
endinterface

// File: rtl/periph_mmio_seg7.sv
// Hex digit to active-low seven-segment pattern {g,f,e,d,c,b,a}; combinational.
module seg7_decode (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/periph_mmio.sv
// Memory-mapped timer / LED / seven-segment peripheral sitting beside data memory
// in the MEM stage. Reads are combinational, writes land on the next edge.
module periph_mmio
  import periph_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          SCAN_DIV  = 100000
) (
  input  logic         clk,
  input  logic         reset,
  periph_mmio_if.slave bus,
  output logic         irq,
  output logic [7:0]   led,
  output logic [7:0]   BCD,
  output logic [3:0]   AN
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [31:0]       th_reg, th_next;
  logic [31:0]       tl_reg, tl_next;
  logic [2:0]        tcon_reg, tcon_next;
  logic [7:0]        led_reg, led_next;
  logic [20:0]       digi_reg, digi_next;
  logic [31:0]       systick_reg;
  logic [SCAN_W-1:0] scan_cnt_reg;
  digit_e            idx_reg, idx_next;
  logic [3:0]        an_reg, an_next;
  logic [7:0]        bcd_reg, bcd_next;

  logic [7:0] byte_off;
  logic       wr_hit;
  logic       scan_tc;
  logic [31:0] rdata;
  logic       unused_addr_bits;

  assign bus.hit   = (bus.Address[31:8] == BASE_ADDR[31:8]);
  assign byte_off  = {bus.Address[7:2], 2'b00};
  assign wr_hit    = bus.MemWrite && bus.hit;
  assign unused_addr_bits = ^bus.Address[1:0];

  always_comb begin
    rdata = 32'h0;
    if (bus.MemRead && bus.hit) begin
      unique case (byte_off)
        OFF_TH:      rdata = th_reg;
        OFF_TL:      rdata = tl_reg;
        OFF_TCON:    rdata = {29'h0, tcon_reg};
        OFF_LED:     rdata = {24'h0, led_reg};
        OFF_DIGI:    rdata = {11'h0, digi_reg};
        OFF_SYSTICK: rdata = systick_reg;
        default:     rdata = 32'h0;
      endcase
    end
  end
  assign bus.Read_data = rdata;

  // Timer first, then CPU writes layered on top so a TL write beats the
  // increment while a same-cycle overflow still sets the status bit.
  always_comb begin
    th_next   = th_reg;
    tl_next   = tl_reg;
    tcon_next = tcon_reg;
    led_next  = led_reg;
    digi_next = digi_reg;
    if (tcon_reg[TCON_EN]) begin
      if (tl_reg == 32'hFFFF_FFFF) begin
        tl_next = th_reg;
      end else begin
        tl_next = tl_reg + 32'd1;
      end
    end
    if (wr_hit) begin
      unique case (byte_off)
        OFF_TH:   th_next   = bus.Write_data;
        OFF_TL:   tl_next   = bus.Write_data;
        OFF_TCON: tcon_next = bus.Write_data[2:0];
        OFF_LED:  led_next  = bus.Write_data[7:0];
        OFF_DIGI: digi_next = bus.Write_data[20:0];
        default:  ;
      endcase
    end
    if (tcon_reg[TCON_EN] && tcon_reg[TCON_IE] && (tl_reg == 32'hFFFF_FFFF)) begin
      tcon_next[TCON_IS] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_reg       <= '0;
      tl_reg       <= '0;
      tcon_reg     <= '0;
      led_reg      <= '0;
      digi_reg     <= '0;
      systick_reg  <= '0;
      scan_cnt_reg <= '0;
    end else begin
      th_reg       <= th_next;
      tl_reg       <= tl_next;
      tcon_reg     <= tcon_next;
      led_reg      <= led_next;
      digi_reg     <= digi_next;
      systick_reg  <= systick_reg + 32'd1;
      scan_cnt_reg <= scan_tc ? '0 : scan_cnt_reg + SCAN_W'(1);
    end
  end

  assign scan_tc = (scan_cnt_reg == SCAN_LAST);

  // Per-digit nibble view of DIGI
  logic [3:0] digit_arr [4];
  logic [3:0] dp_vec;
  logic [6:0] seg_code;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign digit_arr[gi] = digi_reg[4*gi +: 4];
  end
  assign dp_vec = digi_reg[19:16];

  seg7_decode u_seg7 (
    .hex (digit_arr[idx_reg]),
    .seg (seg_code)
  );

  always_comb begin
    idx_next = idx_reg;
    an_next  = 4'hF;
    bcd_next = 8'hFF;
    if (scan_tc) begin
      unique case (idx_reg)
        DIG0:    idx_next = DIG1;
        DIG1:    idx_next = DIG2;
        DIG2:    idx_next = DIG3;
        default: idx_next = DIG0;
      endcase
    end
    if (digi_reg[20]) begin
      an_next  = an_onehot_n(idx_reg);
      bcd_next = {~dp_vec[idx_reg], seg_code};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_reg <= DIG0;
      an_reg  <= 4'hF;
      bcd_reg <= 8'hFF;
    end else begin
      idx_reg <= idx_next;
      an_reg  <= an_next;
      bcd_reg <= bcd_next;
    end
  end

  assign irq = tcon_reg[TCON_IE] & tcon_reg[TCON_IS];
  assign led = led_reg;
  assign AN  = an_reg;
  assign BCD = bcd_reg;

endmodule

// File: tb/tb_periph_mmio.sv
// Randomized and directed bench for periph_mmio against a cycle-level reference model.
module tb_periph_mmio;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          SDIV = 4;

  logic       clk;
  logic       reset;
  logic       irq;
  logic [7:0] led;
  logic [7:0] BCD;
  logic [3:0] AN;

  periph_mmio_if bus ();

  periph_mmio #(.BASE_ADDR(BASE), .SCAN_DIV(SDIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq),
    .led   (led),
    .BCD   (BCD),
    .AN    (AN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Full active-low codes including the dp bit (set = off)
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [20:0] m_digi;
  logic [3:0]  m_an;
  logic [7:0]  m_bcd;
  int unsigned m_edges;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_systick = 0; m_tcon = 0; m_led = 0; m_digi = 0;
    m_an = 4'hF; m_bcd = 8'hFF; m_edges = 0;
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    return a[31:8] == BASE[31:8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
    logic [7:0] off;
    off = {a[7:2], 2'b00};
    if (!(rd && model_hit(a))) return 32'h0;
    case (off)
      8'h00:   return m_th;
      8'h04:   return m_tl;
      8'h08:   return {29'h0, m_tcon};
      8'h0C:   return {24'h0, m_led};
      8'h10:   return {11'h0, m_digi};
      8'h14:   return m_systick;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model across one rising edge using the pre-edge state
  task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic wr);
    int unsigned idx;
    logic [3:0]  nib;
    logic [3:0]  one;
    logic [7:0]  s;
    logic [31:0] n_th, n_tl;
    logic [2:0]  n_tcon;
    logic        ovf;
    idx = (m_edges / SDIV) % 4;
    if (m_digi[20]) begin
      one   = 4'b0001 << idx;
      m_an  = ~one;
      nib   = 4'((m_digi >> (4 * idx)) & 21'hF);
      s     = seg_tab[nib];
      m_bcd = {~m_digi[16 + idx], s[6:0]};
    end else begin
      m_an  = 4'hF;
      m_bcd = 8'hFF;
    end
    n_th = m_th; n_tl = m_tl; n_tcon = m_tcon; ovf = 1'b0;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        n_tl = m_th;
        ovf  = m_tcon[1];
      end else begin
        n_tl = m_tl + 1;
      end
    end
    if (wr && model_hit(a)) begin
      case ({a[7:2], 2'b00})
        8'h00: n_th = wd;
        8'h04: n_tl = wd;
        8'h08: n_tcon = wd[2:0];
        8'h0C: m_led = wd[7:0];
        8'h10: m_digi = wd[20:0];
        default: ;
      endcase
    end
    if (ovf) n_tcon[2] = 1'b1;
    m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
    m_systick = m_systick + 1;
    m_edges++;
  endtask

  // One bus transaction: called at a negedge, returns at the next negedge
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr);
    bus.Address = a; bus.Write_data = wd; bus.MemRead = rd; bus.MemWrite = wr;
    #1;
    chk("hit", {31'h0, bus.hit}, {31'h0, model_hit(a)});
    chk("rdata", bus.Read_data, model_read(a, rd));
    $display("[TB] txn addr=%h wd=%h rd=%0b wr=%0b rdata=%h led=%h AN=%h BCD=%h irq=%0b",
             a, wd, rd, wr, bus.Read_data, led, AN, BCD, irq);
    @(posedge clk);
    model_edge(a, wd, wr);
    @(negedge clk);
    chk("led", {24'h0, led}, {24'h0, m_led});
    chk("AN", {28'h0, AN}, {28'h0, m_an});
    chk("BCD", {24'h0, BCD}, {24'h0, m_bcd});
    chk("irq", {31'h0, irq}, {31'h0, m_tcon[1] & m_tcon[2]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(BASE + 32'h04, 32'h0, 1'b1, 1'b0);
  endtask

  // Assert reset between edges and check outputs before any clock edge
  task automatic do_reset();
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_BCD", {24'h0, BCD}, 32'hFF);
    chk("rst_AN", {28'h0, AN}, 32'hF);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a, wd;
    int r;
    reset = 1'b0;
    bus.Address = 0; bus.Write_data = 0; bus.MemRead = 0; bus.MemWrite = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reads straight after reset, SYSTICK first
    step(BASE + 32'h14, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(BASE + 32'(4 * i), 0, 1, 0);

    // Timer count, reload and irq clear
    step(BASE + 32'h00, 32'hFFFF_FFFD, 0, 1);
    step(BASE + 32'h04, 32'hFFFF_FFFD, 0, 1);
    step(BASE + 32'h08, 32'h3, 0, 1);
    idle(4);
    step(BASE + 32'h08, 32'h3, 0, 1);
    step(BASE + 32'h08, 32'h0, 1, 0);

    // Overflow collides with a TCON write, then TL write during increment
    step(BASE + 32'h04, 32'hFFFF_FFFF, 0, 1);
    step(BASE + 32'h08, 32'h3, 0, 1);
    step(BASE + 32'h08, 32'h0, 1, 0);
    step(BASE + 32'h04, 32'h5, 0, 1);
    step(BASE + 32'h04, 32'h0, 1, 0);
    step(BASE + 32'h08, 32'h0, 0, 1);

    // Display scan
    step(BASE + 32'h10, 32'h0011_1234, 0, 1);
    for (int i = 0; i < 18; i++) step(BASE + 32'h10, 0, 1, 0);
    step(BASE + 32'h10, 32'h0, 0, 1);
    idle(2);

    // LED access, read gating, unmapped and read-only offsets
    step(BASE + 32'h0C, 32'hA5, 0, 1);
    step(BASE + 32'h0C, 0, 1, 0);
    step(BASE + 32'h0C, 0, 0, 0);
    step(BASE + 32'h18, 0, 1, 0);
    step(BASE + 32'h14, 32'h1234_5678, 0, 1);
    step(BASE + 32'h14, 0, 1, 0);

    // Out-of-window stores
    step(32'h0000_000C, 32'h5A, 0, 1);
    step(BASE + 32'h100, 32'h5A, 1, 1);
    step(BASE + 32'h0C, 0, 1, 0);
    step(BASE + 32'h14, 0, 1, 0);
    idle(7);
    step(BASE + 32'h14, 0, 1, 0);

    // Reset mid-scan and mid-count
    step(BASE + 32'h10, 32'h001F_FFFF, 0, 1);
    step(BASE + 32'h08, 32'h3, 0, 1);
    idle(6);
    do_reset();
    step(BASE + 32'h14, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(BASE + 32'(4 * i), 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = BASE + 32'(4 * $urandom_range(0, 7));
      else if (r == 7) a = BASE + 32'($urandom_range(0, 255));
      else if (r == 8) a = $urandom;
      else             a = BASE + 32'h100;
      if ($urandom_range(0, 3) == 0) wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           wd = $urandom;
      step(a, wd, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
